// File: rtl/mem_wb_backend_pkg.sv
// Shared definitions for the MEM/WB back end: access-size encodings and the
// alignment, store-lane and load-extension helpers used by the pipeline.
package mem_wb_backend_pkg;

  localparam logic [2:0] MEMOP_WORD  = 3'b000;
  localparam logic [2:0] MEMOP_HALF  = 3'b001;
  localparam logic [2:0] MEMOP_HALFU = 3'b101;
  localparam logic [2:0] MEMOP_BYTE  = 3'b010;
  localparam logic [2:0] MEMOP_BYTEU = 3'b110;

  // Unknown encodings are treated as word accesses throughout.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
    logic bad;
    case (op)
      MEMOP_WORD:               bad = (lane != 2'd0);
      MEMOP_HALF, MEMOP_HALFU:  bad = lane[0];
      MEMOP_BYTE, MEMOP_BYTEU:  bad = 1'b0;
      default:                  bad = (lane != 2'd0);
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_lanes(input logic [2:0] op, input logic [1:0] lane);
    logic [3:0] be;
    case (op)
      MEMOP_HALF, MEMOP_HALFU:  be = lane[1] ? 4'b1100 : 4'b0011;
      MEMOP_BYTE, MEMOP_BYTEU:  be = 4'b0001 << lane;
      default:                  be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store operand across every lane so the byte enables pick the right one.
  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] data);
    logic [31:0] d;
    case (op)
      MEMOP_HALF, MEMOP_HALFU:  d = {2{data[15:0]}};
      MEMOP_BYTE, MEMOP_BYTEU:  d = {4{data[7:0]}};
      default:                  d = data;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      MEMOP_HALF:   r = {{16{h[15]}}, h};
      MEMOP_HALFU:  r = {16'd0, h};
      MEMOP_BYTE:   r = {{24{b[7]}}, b};
      MEMOP_BYTEU:  r = {24'd0, b};
      default:      r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_wb_backend_data_mem.sv
// Word-organised data memory with per-byte write enables and an
// asynchronous read port sharing the same address.
module mem_wb_backend_data_mem #(
  parameter int DMEM_DEPTH = 256,
  localparam int AW = $clog2(DMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DMEM_DEPTH];

  // Byte-lane write; lanes with a clear enable keep their previous contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_backend.sv
// EX/MEM register, data memory access, MEM/WB register and write-back select
// for the back half of the 5-stage MIPS pipeline.
module mem_wb_backend
  import mem_wb_backend_pkg::*;
#(
  parameter int DMEM_DEPTH = 256,
  localparam int DMEM_AW = $clog2(DMEM_DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_ex,
  input  logic        MemtoReg_ex,
  input  logic        MemWrite_ex,
  input  logic [2:0]  MemOp_ex,
  input  logic [4:0]  RegWriteAddr_ex,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  RegWriteAddr_mem,
  output logic        RegWrite_mem,
  output logic        MisAlign_mem,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  RegWriteAddr_wb,
  output logic        RegWrite_wb
);

  logic              mem_to_reg_mem;
  logic              mem_write_mem;
  logic [2:0]        mem_op_mem;
  logic [31:0]       mem_write_data_mem;

  logic [31:0]       alu_result_wb;
  logic [31:0]       mem_data_wb;
  logic              mem_to_reg_wb;

  logic [1:0]        lane;
  logic              bad_align;
  logic              store_en;
  logic [31:0]       read_word;
  logic [31:0]       load_data;

  // EX/MEM pipeline register; a write to $0 is dropped here so neither stage sees it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResult_mem      <= 32'd0;
      RegWriteAddr_mem   <= 5'd0;
      RegWrite_mem       <= 1'b0;
      mem_to_reg_mem     <= 1'b0;
      mem_write_mem      <= 1'b0;
      mem_op_mem         <= 3'd0;
      mem_write_data_mem <= 32'd0;
    end else begin
      ALUResult_mem      <= ALUResult_ex;
      RegWriteAddr_mem   <= RegWriteAddr_ex;
      RegWrite_mem       <= RegWrite_ex & (RegWriteAddr_ex != 5'd0);
      mem_to_reg_mem     <= MemtoReg_ex;
      mem_write_mem      <= MemWrite_ex;
      mem_op_mem         <= MemOp_ex;
      mem_write_data_mem <= MemWriteData_ex;
    end
  end

  assign lane         = ALUResult_mem[1:0];
  assign bad_align    = misaligned(mem_op_mem, lane);
  assign MisAlign_mem = (mem_write_mem | mem_to_reg_mem) & bad_align;
  // Reset wins over a store sitting in MEM.
  assign store_en     = mem_write_mem & ~bad_align & ~reset;

  mem_wb_backend_data_mem #(
    .DMEM_DEPTH (DMEM_DEPTH)
  ) u_data_mem (
    .clk   (clk),
    .we    (store_en),
    .be    (store_lanes(mem_op_mem, lane)),
    .addr  (ALUResult_mem[DMEM_AW+1:2]),
    .wdata (store_data(mem_op_mem, mem_write_data_mem)),
    .rdata (read_word)
  );

  assign load_data = bad_align ? 32'd0 : load_extend(mem_op_mem, lane, read_word);

  // MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_wb   <= 32'd0;
      mem_data_wb     <= 32'd0;
      mem_to_reg_wb   <= 1'b0;
      RegWriteAddr_wb <= 5'd0;
      RegWrite_wb     <= 1'b0;
    end else begin
      alu_result_wb   <= ALUResult_mem;
      mem_data_wb     <= load_data;
      mem_to_reg_wb   <= mem_to_reg_mem;
      RegWriteAddr_wb <= RegWriteAddr_mem;
      RegWrite_wb     <= RegWrite_mem;
    end
  end

  assign RegWriteData_wb = mem_to_reg_wb ? mem_data_wb : alu_result_wb;

endmodule

// File: doc/mem_wb_backend.md
Name: mem_wb_backend

Overview:
- Back half of the static 5-stage MIPS pipeline: EX/MEM register, data memory access, MEM/WB register and write-back select.
- Produces the forwarding sources consumed by the EX stage (ALUResult_mem, RegWriteAddr_mem, RegWrite_mem, RegWriteData_wb, RegWriteAddr_wb, RegWrite_wb) and the register-file write port.
- Supports word, halfword and byte loads/stores, with sign or zero extension on loads.

Parameters:
- DMEM_DEPTH, 256, data memory size in 32-bit words (power of 2).
- DMEM_AW, log2(DMEM_DEPTH), word-address width (derived, not overridable).

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- RegWrite_ex  in  1  EX-stage instruction writes the register file
- MemtoReg_ex  in  1  write-back value comes from memory (load)
- MemWrite_ex  in  1  store
- MemOp_ex  in  3  access size/extension, encoded per pkg
- RegWriteAddr_ex  in  5  destination register
- ALUResult_ex  in  32  ALU result / effective address
- MemWriteData_ex  in  32  forwarded Rt data for stores
- ALUResult_mem  out  32  EX/MEM ALU result (forwarding source)
- RegWriteAddr_mem  out  5  EX/MEM destination
- RegWrite_mem  out  1  EX/MEM write enable
- MisAlign_mem  out  1  current MEM access is misaligned
- RegWriteData_wb  out  32  final write-back data
- RegWriteAddr_wb  out  5  MEM/WB destination
- RegWrite_wb  out  1  MEM/WB write enable

Behaviour:
- One clk; reset is synchronous and active-high; ports are named clk and reset.
- Reset: all EX/MEM and MEM/WB fields are cleared to 0, so every output reads 0 the cycle after reset. Memory array contents are not cleared.
- Reset has priority over capture. A store in MEM during the reset cycle is not written.
- EX/MEM capture:
  - Every rising edge, EX inputs are captured. There is no stall or enable; bubbles arrive as all-zero controls.
  - If RegWriteAddr_ex==0, RegWrite is forced to 0 at capture. This applies to both the _mem and _wb copies.
- MEM stage:
  - Word index = ALUResult_mem[DMEM_AW+1:2]. Higher address bits are ignored, so addresses wrap modulo DMEM_DEPTH*4.
- MemOp encoding:
  - WORD (000): requires addr[1:0]==0.
  - HALF (001, sign-extended) and HALFU (101, zero-extended): require addr[0]==0.
  - BYTE (010, sign-extended) and BYTEU (110, zero-extended): any alignment.
  - Byte lane selected by addr[1:0], little-endian: lane 0 = bits 7:0.
- Misalignment: MisAlign_mem = (MemWrite_mem|MemtoReg_mem) & misaligned, combinational.
- Store:
  - Written at the rising edge ending the MEM cycle. Byte-enable read-modify-write; untouched lanes are preserved.
  - A misaligned store is suppressed.
- Load:
  - Array read combinationally at ALUResult_mem, then lane-extracted and extended.
  - Result captured into the MEM/WB MemData field at the next edge.
  - A misaligned load yields 0; RegWrite is still honoured.
- Store in MEM at cycle t followed by a load of the same word in MEM at t+1: the load returns the new data. Write-before-read ordering is ensured by the edge.
- MEM/WB capture: ALUResult, MemData, MemtoReg, RegWriteAddr and RegWrite are captured every edge.
- Write-back: RegWriteData_wb = MemtoReg_wb ? MemData_wb : ALUResult_wb, combinational.
- Latency: EX input to _mem outputs takes 1 edge. EX input to _wb outputs takes 2 edges.
- Simultaneous MemWrite_ex and MemtoReg_ex is illegal from the decoder. If it occurs, the store executes and write-back selects memory, i.e. the old data.

Decomposition:
- Shared package: MemOp encodings (MEMOP_WORD/HALF/HALFU/BYTE/BYTEU), the misalignment function, and the load-extension function.
- Natural sub-module: data_mem, holding the array plus byte-enable write and combinational read. It is parameterised by DMEM_DEPTH, so the top keeps only the pipeline registers and muxes.

Test Plan:
- ALU pass-through: RegWrite_ex=1, Addr=5, ALUResult_ex=0x12345678, MemtoReg=0 -> _mem outputs after 1 edge; RegWriteData_wb=0x12345678, RegWriteAddr_wb=5 after 2 edges.
- Word store/load: store 0xDEADBEEF at 0x10, then next cycle LW to r3 from 0x10 -> RegWriteData_wb=0xDEADBEEF, RegWrite_wb=1 two edges after the LW.
- Sub-word:
  - SB 0x80 to 0x13 over 0x00000000, then LB from 0x13 -> 0xFFFFFF80; LBU -> 0x00000080.
  - Word at 0x10 then reads 0x80000000.
  - SH 0xBEEF to 0x12, then LH -> 0xFFFFBEEF.
- Misaligned: SW to 0x11 -> MisAlign_mem=1 during MEM, memory unchanged; LW from 0x12 -> MisAlign_mem=1, RegWriteData_wb=0.
- $0 suppression: RegWrite_ex=1, Addr=0 -> RegWrite_mem=0, then RegWrite_wb=0.
- Reset mid-stream: reset asserted with a store in MEM and a load in WB -> store not written, all outputs 0 after the edge; wrap check: store to 0x400 with DMEM_DEPTH=256 aliases word 0.
